// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32x32 multiply / 32/32 divide sequencer driving a shared external ALU
module muldiv_seq #(
    parameter logic [4:0] ALU_ADD = 5'h0,
    parameter logic [4:0] ALU_SUB = 5'h1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic [4:0]  alu_conf,
    output logic        alu_sign,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_result
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;
    state_t      state;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r, acc, sh, mb;
    logic [4:0]  cnt;
    logic        neg_q, neg_r;
    logic [31:0] abs_a, abs_b, rp;
    logic [63:0] prod;
    logic        carry, take;
    assign abs_a = (op_r[0] && a_r[31]) ? -a_r : a_r;
    assign abs_b = (op_r[0] && b_r[31]) ? -b_r : b_r;
    assign rp    = {acc[30:0], sh[31]};
    assign carry = alu_result < acc;
    assign take  = acc[31] | (rp >= mb);
    assign prod  = neg_q ? -{acc, sh} : {acc, sh};
    // ALU operands: add step for multiply, trial subtract for divide, idle values otherwise
    always_comb begin
        alu_sign = 1'b0;
        alu_conf = (state == ITER && op_r[1]) ? ALU_SUB : ALU_ADD;
        alu_in1  = (state != ITER) ? 32'h0 : op_r[1] ? rp : acc;
        alu_in2  = (state != ITER) ? 32'h0 : (op_r[1] || sh[0]) ? mb : 32'h0;
    end
    // Sequencer: latch request, form magnitudes, 32 shift/add or shift/subtract steps, fix signs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= 32'h0;
            lo          <= 32'h0;
            div_by_zero <= 1'b0;
            op_r        <= 2'b0;
            a_r         <= 32'h0;
            b_r         <= 32'h0;
            acc         <= 32'h0;
            sh          <= 32'h0;
            mb          <= 32'h0;
            cnt         <= 5'd0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (op_r[1] && b_r == 32'h0) begin
                        hi          <= a_r;
                        lo          <= 32'hFFFFFFFF;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        acc   <= 32'h0;
                        sh    <= op_r[1] ? abs_a : abs_b;
                        mb    <= op_r[1] ? abs_b : abs_a;
                        neg_q <= op_r[0] & (a_r[31] ^ b_r[31]);
                        neg_r <= op_r[0] & a_r[31];
                        cnt   <= 5'd0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    acc <= op_r[1] ? (take ? alu_result : rp) : {carry, alu_result[31:1]};
                    sh  <= op_r[1] ? {sh[30:0], take} : {alu_result[0], sh[31:1]};
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    hi          <= op_r[1] ? (neg_r ? -acc : acc) : prod[63:32];
                    lo          <= op_r[1] ? (neg_q ? -sh : sh) : prod[31:0];
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq with a behavioural add/sub ALU
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b0;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic        busy, done, div_by_zero, alu_sign;
    logic [31:0] hi, lo, alu_in1, alu_in2, alu_result;
    logic [4:0]  alu_conf;
    int          checks = 0, failures = 0;

    typedef struct packed {logic [31:0] hi; logic [31:0] lo; logic dbz;} res_t;
    res_t sbq[$];

    muldiv_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
        .alu_conf(alu_conf), .alu_sign(alu_sign), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result)
    );

    assign alu_result = (alu_conf == 5'h1) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;

    always #5 clk = ~clk;

    function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[1] && y == 32'h0) return '{x, 32'hFFFFFFFF, 1'b1};
        case (o)
            2'd0: p = {32'h0, x} * {32'h0, y};
            2'd1: p = 64'(sx * sy);
            2'd2: p = {x % y, x / y};
            default: begin
                q = sx / sy;
                r = sx % sy;
                p = {32'(r), 32'(q)};
            end
        endcase
        return '{p[63:32], p[31:0], 1'b0};
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        sbq.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy/done/dbz=%b hi=%h lo=%h required 000/0/0", {busy, done, div_by_zero}, hi, lo);
        end
        checks++;
        if (alu_conf !== 5'h0 || alu_sign !== 1'b0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_alu: conf=%h sign=%b in1=%h in2=%h required 0", alu_conf, alu_sign, alu_in1, alu_in2);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_multiply;
        logic [1:0]  to[6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
        logic [31:0] ta[6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'd7};
        logic [31:0] tb[6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'hFFFFFFF7};
        res_t r;
        int n;
        for (int i = 0; i < 6; i++) begin
            issue(to[i], ta[i], tb[i]);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL mul_busy[%0d]: busy=%b required 1", i, busy);
            end
            wait_done(n);
            checks++;
            if (n !== 34) begin
                failures++;
                $display("FAIL mul_latency[%0d]: edges=%0d required 34", i, n);
            end
            r = sbq.pop_front();
            checks++;
            if (hi !== r.hi || lo !== r.lo || div_by_zero !== r.dbz) begin
                failures++;
                $display("FAIL mul_result[%0d]: hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b", i, hi, lo, div_by_zero, r.hi, r.lo, r.dbz);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || hi !== r.hi || lo !== r.lo) begin
                failures++;
                $display("FAIL mul_hold[%0d]: done=%b hi=%h lo=%h required done=0 hi=%h lo=%h", i, done, hi, lo, r.hi, r.lo);
            end
        end
    endtask

    task automatic test_divide;
        logic [1:0]  to[6] = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
        logic [31:0] ta[6] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7, 32'hFFFFFFFF, 32'd5};
        logic [31:0] tb[6] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd9};
        res_t r;
        int n;
        for (int i = 0; i < 6; i++) begin
            issue(to[i], ta[i], tb[i]);
            wait_done(n);
            checks++;
            if (n !== 34) begin
                failures++;
                $display("FAIL div_latency[%0d]: edges=%0d required 34", i, n);
            end
            r = sbq.pop_front();
            checks++;
            if (hi !== r.hi || lo !== r.lo || div_by_zero !== r.dbz) begin
                failures++;
                $display("FAIL div_result[%0d]: hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b", i, hi, lo, div_by_zero, r.hi, r.lo, r.dbz);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_by_zero;
        logic [1:0]  to[3] = '{2'd2, 2'd0, 2'd3};
        logic [31:0] ta[3] = '{32'h12345678, 32'd2, 32'hDEADBEEF};
        logic [31:0] tb[3] = '{32'd0, 32'd3, 32'd0};
        int          tl[3] = '{1, 34, 1};
        res_t r;
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(to[i], ta[i], tb[i]);
            wait_done(n);
            checks++;
            if (n !== tl[i]) begin
                failures++;
                $display("FAIL dbz_latency[%0d]: edges=%0d required %0d", i, n, tl[i]);
            end
            r = sbq.pop_front();
            checks++;
            if (hi !== r.hi || lo !== r.lo || div_by_zero !== r.dbz) begin
                failures++;
                $display("FAIL dbz_result[%0d]: hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b", i, hi, lo, div_by_zero, r.hi, r.lo, r.dbz);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_start;
        res_t r;
        int n;
        issue(2'd0, 32'd7, 32'd9);
        repeat (11) @(posedge clk);
        #1;
        op = 2'd3; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        checks++;
        if (n + 12 !== 34) begin
            failures++;
            $display("FAIL ignore_latency: edges=%0d required 34", n + 12);
        end
        r = sbq.pop_front();
        checks++;
        if (hi !== r.hi || lo !== r.lo) begin
            failures++;
            $display("FAIL ignore_result: hi=%h lo=%h required hi=%h lo=%h", hi, lo, r.hi, r.lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        res_t r;
        int n;
        @(negedge clk);
        op = 2'd1; a = 32'hFFFFFFFD; b = 32'd5; start = 1'b1;
        sbq.push_back(model(2'd1, 32'hFFFFFFFD, 32'd5));
        @(posedge clk);
        #1;
        wait_done(n);
        checks++;
        if (n !== 34) begin
            failures++;
            $display("FAIL b2b_latency0: edges=%0d required 34", n);
        end
        r = sbq.pop_front();
        checks++;
        if (hi !== r.hi || lo !== r.lo) begin
            failures++;
            $display("FAIL b2b_result0: hi=%h lo=%h required hi=%h lo=%h", hi, lo, r.hi, r.lo);
        end
        op = 2'd2; a = 32'd1000; b = 32'd33;
        sbq.push_back(model(2'd2, 32'd1000, 32'd33));
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy: busy=%b done=%b required 1 0", busy, done);
        end
        start = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 34) begin
            failures++;
            $display("FAIL b2b_latency1: edges=%0d required 34", n);
        end
        r = sbq.pop_front();
        checks++;
        if (hi !== r.hi || lo !== r.lo || div_by_zero !== r.dbz) begin
            failures++;
            $display("FAIL b2b_result1: hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b", hi, lo, div_by_zero, r.hi, r.lo, r.dbz);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop;
        res_t r;
        int n, seen;
        issue(2'd0, 32'hFFFFFFFF, 32'd2);
        wait_done(n);
        r = sbq.pop_front();
        checks++;
        if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL rst_pre_result: hi=%h lo=%h required hi=00000001 lo=fffffffe", hi, lo);
        end
        @(posedge clk);
        #1;
        issue(2'd1, 32'h01234567, 32'h00000321);
        void'(sbq.pop_back());
        repeat (21) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin
            failures++;
            $display("FAIL rst_async: busy=%b done=%b hi=%h lo=%h in1=%h in2=%h required all 0", busy, done, hi, lo, alu_in1, alu_in2);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_no_done: active cycles=%0d required 0", seen);
        end
        issue(2'd3, 32'd50, 32'hFFFFFFF9);
        wait_done(n);
        checks++;
        if (n !== 34) begin
            failures++;
            $display("FAIL rst_post_latency: edges=%0d required 34", n);
        end
        r = sbq.pop_front();
        checks++;
        if (hi !== r.hi || lo !== r.lo || div_by_zero !== r.dbz) begin
            failures++;
            $display("FAIL rst_post_result: hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b", hi, lo, div_by_zero, r.hi, r.lo, r.dbz);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_multiply;
        test_divide;
        test_div_by_zero;
        test_ignore_start;
        test_back_to_back;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
